// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the CPU memory bus arbiter and its OAM DMA sequencer.
package mem_bus_arbiter_pkg;

    localparam int unsigned REG_WIDTH  = 8;
    localparam int unsigned ADDR_WIDTH = 16;
    localparam int unsigned IDX_WIDTH  = ADDR_WIDTH - REG_WIDTH;

    localparam logic [ADDR_WIDTH-1:0] DMA_TRIGGER_ADDR = 16'h4014;
    localparam logic [ADDR_WIDTH-1:0] DMA_DEST_ADDR    = 16'h2004;

    typedef enum logic [2:0] {
        ARB_IDLE      = 3'd0,
        ARB_DMA_HALT  = 3'd1,
        ARB_DMA_ALIGN = 3'd2,
        ARB_DMA_READ  = 3'd3,
        ARB_DMA_WRITE = 3'd4
    } arb_state_e;

    typedef enum logic {
        REQ_FETCH = 1'b0,
        REQ_EXEC  = 1'b1
    } req_id_e;

    // Bus action the DMA wants placed on the bus next cycle; drive=0 keeps the address lines.
    typedef struct packed {
        logic                  drive;
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [REG_WIDTH-1:0]  wdata;
    } dma_bus_t;

endpackage

// File: rtl/mem_bus_arbiter_oam_dma_sequencer.sv
// Sprite DMA sequencer: halt, optional alignment cycle, then 256 read/write pairs.
module mem_bus_arbiter_oam_dma_sequencer
    import mem_bus_arbiter_pkg::*;
#(
    parameter logic [ADDR_WIDTH-1:0] DEST_ADDR = DMA_DEST_ADDR
) (
    input  logic                 phi1,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [REG_WIDTH-1:0] start_page,
    input  logic                 parity,
    input  logic [REG_WIDTH-1:0] mem_rdata,
    output logic                 busy_c,
    output dma_bus_t             bus_c
);

    arb_state_e           state_q, state_d;
    logic [REG_WIDTH-1:0] page_q, page_d;
    logic [IDX_WIDTH-1:0] idx_q, idx_d;

    // State, page and index registers; reset abandons any copy in flight.
    always_ff @(posedge phi1 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ARB_IDLE;
            page_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state sequencing of the copy.
    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        idx_d   = idx_q;
        case (state_q)
            ARB_IDLE: begin
                if (start) begin
                    page_d  = start_page;
                    idx_d   = '0;
                    state_d = ARB_DMA_HALT;
                end
            end
            ARB_DMA_HALT:  state_d = parity ? ARB_DMA_ALIGN : ARB_DMA_READ;
            ARB_DMA_ALIGN: state_d = ARB_DMA_READ;
            ARB_DMA_READ:  state_d = ARB_DMA_WRITE;
            ARB_DMA_WRITE: begin
                idx_d   = IDX_WIDTH'(idx_q + 1'b1);
                state_d = (idx_q == {IDX_WIDTH{1'b1}}) ? ARB_IDLE : ARB_DMA_READ;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    assign busy_c = (state_q != ARB_IDLE);

    // Bus-request view; the write cycle forwards the byte read in the preceding cycle.
    always_comb begin
        bus_c = '0;
        case (state_q)
            ARB_DMA_READ: begin
                bus_c.drive = 1'b1;
                bus_c.addr  = {page_q, idx_q};
            end
            ARB_DMA_WRITE: begin
                bus_c.drive = 1'b1;
                bus_c.we    = 1'b1;
                bus_c.addr  = DEST_ADDR;
                bus_c.wdata = mem_rdata;
            end
            default: bus_c = '0;
        endcase
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// CPU memory bus arbiter: round-robin between fetch and execute, with sprite DMA takeover.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter logic [ADDR_WIDTH-1:0] TRIGGER_ADDR = DMA_TRIGGER_ADDR,
    parameter logic [ADDR_WIDTH-1:0] DEST_ADDR    = DMA_DEST_ADDR
) (
    input  logic                  phi1,
    input  logic                  reset_n,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic                  fetch_grant,
    input  logic                  exec_req,
    input  logic                  exec_we,
    input  logic [ADDR_WIDTH-1:0] exec_addr,
    input  logic [REG_WIDTH-1:0]  exec_wdata,
    output logic                  exec_grant,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [REG_WIDTH-1:0]  mem_wdata,
    output logic                  mem_we,
    input  logic [REG_WIDTH-1:0]  mem_rdata,
    output logic                  cpu_halt,
    output logic                  dma_active
);

    logic     parity_q;
    req_id_e  last_grant_q;
    logic     dma_busy_c;
    dma_bus_t dma_bus_c;
    logic     grant_fetch_c;
    logic     grant_exec_c;
    logic     dma_start_c;

    mem_bus_arbiter_oam_dma_sequencer #(
        .DEST_ADDR (DEST_ADDR)
    ) u_dma (
        .phi1       (phi1),
        .reset_n    (reset_n),
        .start      (dma_start_c),
        .start_page (exec_wdata),
        .parity     (parity_q),
        .mem_rdata  (mem_rdata),
        .busy_c     (dma_busy_c),
        .bus_c      (dma_bus_c)
    );

    // Round-robin pick; nothing is granted while the DMA owns the bus.
    always_comb begin
        grant_fetch_c = 1'b0;
        grant_exec_c  = 1'b0;
        if (!dma_busy_c) begin
            if (fetch_req && exec_req) begin
                if (last_grant_q == REQ_FETCH) grant_exec_c  = 1'b1;
                else                           grant_fetch_c = 1'b1;
            end else if (fetch_req) begin
                grant_fetch_c = 1'b1;
            end else if (exec_req) begin
                grant_exec_c = 1'b1;
            end
        end
    end

    assign dma_start_c = grant_exec_c && exec_we && (exec_addr == TRIGGER_ADDR);

    // Output registers, parity and round-robin history.
    always_ff @(posedge phi1 or negedge reset_n) begin
        if (!reset_n) begin
            parity_q     <= 1'b0;
            last_grant_q <= REQ_FETCH;
            fetch_grant  <= 1'b0;
            exec_grant   <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_we       <= 1'b0;
            cpu_halt     <= 1'b0;
            dma_active   <= 1'b0;
        end else begin
            parity_q    <= ~parity_q;
            fetch_grant <= grant_fetch_c;
            exec_grant  <= grant_exec_c;
            cpu_halt    <= dma_busy_c;
            dma_active  <= dma_busy_c;
            if (dma_busy_c) begin
                mem_we <= dma_bus_c.we;
                if (dma_bus_c.drive) mem_addr  <= dma_bus_c.addr;
                if (dma_bus_c.we)    mem_wdata <= dma_bus_c.wdata;
            end else if (grant_exec_c) begin
                mem_addr     <= exec_addr;
                mem_we       <= exec_we;
                last_grant_q <= REQ_EXEC;
                if (exec_we) mem_wdata <= exec_wdata;
            end else if (grant_fetch_c) begin
                mem_addr     <= fetch_addr;
                mem_we       <= 1'b0;
                last_grant_q <= REQ_FETCH;
            end else begin
                mem_we <= 1'b0;
            end
        end
    end

endmodule
